// File: rtl/multi_lane_arq_sender_if.sv
// Handshake/data bundle between packet logic and the multi-lane ARQ sender.
// The master side drives payload, update and ACK signals; the slave side drives the serial lines and link status.
interface multi_lane_arq_sender_if #(
  parameter int NUM_LANES    = 4,
  parameter int PAYLOAD_BITS = 836,
  parameter int MAX_RETRIES  = 7
);
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  logic                    game_active;
  logic                    update_data;
  logic [PAYLOAD_BITS-1:0] payload;
  logic                    ack_received;
  logic                    ack_seqNum;
  logic [NUM_LANES-1:0]    serial_out;
  logic                    busy;
  logic                    send_done;
  logic                    link_fail;
  logic [RW-1:0]           retry_count;
  logic                    seq_out;

  modport master (
    output game_active, update_data, payload, ack_received, ack_seqNum,
    input  serial_out, busy, send_done, link_fail, retry_count, seq_out
  );

  modport slave (
    input  game_active, update_data, payload, ack_received, ack_seqNum,
    output serial_out, busy, send_done, link_fail, retry_count, seq_out
  );
endinterface

// File: rtl/multi_lane_arq_sender.sv
// Stop-and-wait ARQ sender striping a latched payload across NUM_LANES serial lines.
// Start bit appears 2 cycles after update_data; newer updates while busy park in a one-entry pending buffer.
module multi_lane_arq_sender #(
  parameter int NUM_LANES      = 4,
  parameter int PAYLOAD_BITS   = 836,
  parameter int CLKS_PER_BIT   = 1,
  parameter int TIMEOUT_CYCLES = 200,
  parameter int MAX_RETRIES    = 7
) (
  input  logic                   i_clk,
  input  logic                   i_rst_l,
  multi_lane_arq_sender_if.slave io_bus
);
  localparam int SLICE     = (PAYLOAD_BITS + NUM_LANES - 1) / NUM_LANES;
  localparam int FRAME_LEN = SLICE + 2;
  localparam int SW        = FRAME_LEN - 1;
  localparam int PADW      = NUM_LANES * SLICE;
  localparam int BW        = $clog2(FRAME_LEN);
  localparam int CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW        = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_WAIT, S_FAIL} state_t;

  state_t               r_state;
  logic [PADW-1:0]      r_tx;
  logic [PADW-1:0]      r_pend;
  logic                 r_pend_vld;
  logic [SW-1:0]        r_shift [NUM_LANES];
  logic [NUM_LANES-1:0] r_serial;
  logic [BW-1:0]        r_bit_cnt;
  logic [CW-1:0]        r_clk_cnt;
  logic [TW-1:0]        r_to_cnt;
  logic [RW-1:0]        r_retry;
  logic                 r_seq;
  logic                 r_busy;
  logic                 r_send_done;
  logic                 r_link_fail;

  logic [PADW-1:0] w_pay_pad;
  logic            w_ack_ok;
  logic            w_timeout;
  logic            w_bit_end;

  assign w_pay_pad = PADW'(io_bus.payload);
  assign w_ack_ok  = io_bus.ack_received && (io_bus.ack_seqNum == r_seq);
  assign w_timeout = (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign w_bit_end = (r_clk_cnt == CW'(CLKS_PER_BIT - 1));

  // r_shift holds the bits still to go; the bit on the line lives in r_serial.
  always_ff @(posedge i_clk or negedge i_rst_l) begin
    if (!i_rst_l) begin
      r_state     <= S_IDLE;
      r_tx        <= '0;
      r_pend      <= '0;
      r_pend_vld  <= 1'b0;
      r_serial    <= '0;
      r_bit_cnt   <= '0;
      r_clk_cnt   <= '0;
      r_to_cnt    <= '0;
      r_retry     <= '0;
      r_seq       <= 1'b0;
      r_busy      <= 1'b0;
      r_send_done <= 1'b0;
      r_link_fail <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) r_shift[i] <= '0;
    end else begin
      r_send_done <= 1'b0;
      if (!io_bus.game_active) begin
        r_state     <= S_IDLE;
        r_pend_vld  <= 1'b0;
        r_serial    <= '0;
        r_bit_cnt   <= '0;
        r_clk_cnt   <= '0;
        r_to_cnt    <= '0;
        r_retry     <= '0;
        r_seq       <= 1'b0;
        r_busy      <= 1'b0;
        r_link_fail <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (io_bus.update_data) begin
              r_tx    <= w_pay_pad;
              r_state <= S_LOAD;
              r_busy  <= 1'b1;
            end
          end
          S_LOAD: begin
            for (int i = 0; i < NUM_LANES; i++)
              r_shift[i] <= {r_seq, r_tx[(NUM_LANES-i)*SLICE-1 -: SLICE]};
            r_serial  <= '1;
            r_bit_cnt <= '0;
            r_clk_cnt <= '0;
            r_state   <= S_SEND;
          end
          S_SEND: begin
            if (w_bit_end) begin
              r_clk_cnt <= '0;
              if (r_bit_cnt == BW'(FRAME_LEN - 1)) begin
                r_serial <= '0;
                r_to_cnt <= '0;
                r_state  <= S_WAIT;
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
                for (int i = 0; i < NUM_LANES; i++) begin
                  r_serial[i] <= r_shift[i][SW-1];
                  r_shift[i]  <= {r_shift[i][SW-2:0], 1'b0};
                end
              end
            end else begin
              r_clk_cnt <= r_clk_cnt + 1'b1;
            end
          end
          S_WAIT: begin
            r_to_cnt <= r_to_cnt + 1'b1;
            if (w_ack_ok) begin
              r_send_done <= 1'b1;
              r_seq       <= ~r_seq;
              r_retry     <= '0;
              if (io_bus.update_data) begin
                r_tx       <= w_pay_pad;
                r_pend_vld <= 1'b0;
                r_state    <= S_LOAD;
              end else if (r_pend_vld) begin
                r_tx       <= r_pend;
                r_pend_vld <= 1'b0;
                r_state    <= S_LOAD;
              end else begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end
            end else if (w_timeout) begin
              if (r_retry < RW'(MAX_RETRIES)) begin
                r_retry <= r_retry + 1'b1;
                r_state <= S_LOAD;
              end else begin
                r_state     <= S_FAIL;
                r_busy      <= 1'b0;
                r_link_fail <= 1'b1;
              end
            end
          end
          S_FAIL: r_link_fail <= 1'b1;
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase

        // An ACK-cycle update is routed straight into r_tx above, so it is excluded here.
        if (io_bus.update_data && r_busy && !(r_state == S_WAIT && w_ack_ok)) begin
          r_pend     <= w_pay_pad;
          r_pend_vld <= 1'b1;
        end
      end
    end
  end

  assign io_bus.serial_out  = r_serial;
  assign io_bus.busy        = r_busy;
  assign io_bus.send_done   = r_send_done;
  assign io_bus.link_fail   = r_link_fail;
  assign io_bus.retry_count = r_retry;
  assign io_bus.seq_out     = r_seq;
endmodule

// File: doc/multi_lane_arq_sender.md
Name: multi_lane_arq_sender

Overview:
Parametrised multi-lane serial packet sender with stop-and-wait ARQ. It latches a packed payload on `update_data` and stripes it across NUM_LANES serial lines. It then waits for a sequence-matched ACK and retransmits on timeout, up to a retry limit. It sits between game logic/packet construction and the GPIO pins, and replaces fixed 4-lane sending with configurable lane count, payload width, bit rate and retry policy.

Parameters:
NUM_LANES, 4, number of serial data lanes (≥1)
PAYLOAD_BITS, 836, packed payload width
CLKS_PER_BIT, 1, clk cycles each serial bit is held (≥1)
TIMEOUT_CYCLES, 200, cycles in WAIT_ACK before retransmit (≥1)
MAX_RETRIES, 7, retransmits allowed before link failure
(derived) SLICE = ceil(PAYLOAD_BITS/NUM_LANES); FRAME_LEN = SLICE+2

Ports:
clk  in  1  system clock
rst_l  in  1  asynchronous active-low reset
game_active  in  1  when low, abort and hold idle
update_data  in  1  1-cycle pulse: payload valid
payload  in  PAYLOAD_BITS  packet contents
ack_received  in  1  1-cycle pulse from receiver
ack_seqNum  in  1  sequence bit carried by the ACK
serial_out  out  NUM_LANES  serial lines, bit i = lane i
busy  out  1  high in LOAD/SEND/WAIT_ACK
send_done  out  1  1-cycle pulse when a packet is acknowledged
link_fail  out  1  sticky: retries exhausted
retry_count  out  $clog2(MAX_RETRIES+1)  retransmits of current packet
seq_out  out  1  sequence bit of current/next packet

Behaviour:
- Reset: state IDLE, `serial_out`=0, `busy`=0, `send_done`=0, `link_fail`=0, `retry_count`=0, `seq_out`=0, pending buffer empty, all counters 0.
- Striping: payload is zero-extended at the MSB to NUM_LANES*SLICE bits. Lane i carries bits [(NUM_LANES-i)*SLICE-1 -: SLICE], so lane 0 gets the most significant slice.
- Frame per lane, MSB-first: start bit 1, seq bit, SLICE data bits. Each bit is held CLKS_PER_BIT cycles. All lanes are bit-aligned. The line is 0 when not in SEND.
- States:
  - IDLE: on `update_data`, capture payload into the transmit register and go to LOAD.
  - LOAD: one cycle; load the lane shift registers and go to SEND. The start bit appears on `serial_out` in the cycle after LOAD, i.e. 2 cycles after `update_data` is sampled.
  - SEND: shift FRAME_LEN*CLKS_PER_BIT cycles, then go to WAIT_ACK. `serial_out` returns to 0 and the timeout counter clears.
  - WAIT_ACK:
    - If `ack_received` and `ack_seqNum==seq_out`: pulse `send_done`, toggle `seq_out`, clear `retry_count`. Go to LOAD if the pending buffer is full (it moves into the transmit register and empties), otherwise go to IDLE.
    - An ACK with a mismatched seq is ignored.
    - When the counter reaches TIMEOUT_CYCLES: if `retry_count<MAX_RETRIES`, increment `retry_count`, reload the identical frame with the same seq, and go to LOAD. Otherwise go to FAIL.
    - An ACK and a timeout in the same cycle: the ACK wins.
  - FAIL: `link_fail`=1, lines 0, `busy`=0. `update_data` is ignored. Leave FAIL only via `game_active` low or reset.
- ACKs arriving in IDLE, LOAD or SEND are ignored.
- Pending buffer: one entry. `update_data` while `busy` overwrites it (newest wins) and never disturbs the frame in flight.
- `update_data` in the same cycle as an ACK acceptance: the new data goes to the pending buffer and is sent next.
- `game_active` low: the next state is IDLE from any state. Lines go to 0 that cycle (registered). Pending buffer, counters and `link_fail` clear, and `seq_out` resets to 0. `update_data` is ignored while `game_active` is low.
- Reset mid-frame: all outputs return immediately (asynchronously) to their reset values.

Test Plan:
All scenarios use NUM_LANES=2, PAYLOAD_BITS=6, CLKS_PER_BIT=1, TIMEOUT_CYCLES=8, MAX_RETRIES=2, `game_active`=1.
1. Basic frame: `update_data` with payload=6'b101100 at cycle 0 -> from cycle 2, lane0 = 1,0,1,0,1 and lane1 = 1,0,1,0,0, then 0. `busy` is high cycles 1–6+.
2. ACK path: after scenario 1, `ack_received`=1 with `ack_seqNum`=0 -> `send_done` pulses 1 cycle, `seq_out`=1, state IDLE. A second packet's frames carry seq bit 1.
3. Wrong/early ACK: an ACK with `ack_seqNum`=1, then any ACK during SEND -> no `send_done`. Retransmit starts 8 cycles after WAIT_ACK entry and `retry_count`=1.
4. Link failure: never ACK -> 3 identical frames in total, then `link_fail`=1, lines 0. Lowering `game_active` clears `link_fail` and `seq_out`.
5. Pending buffer: `update_data` A, then B and C during SEND of A, then ACK A -> next frame carries C and B is never sent.
6. Simultaneous ACK and timeout in the same cycle -> `send_done` pulses and no retransmit. Asserting `rst_l` low mid-SEND drives all outputs to 0 at once.
